// File: rtl/ulpi_tx_engine.sv
// ulpi_tx_engine
// Link-side ULPI transmit engine. For each accepted request it drives a
// TX CMD byte ({4'b0100, pid}), then the payload bytes paced by the PHY's
// nxt, then a one-cycle stp. It gives the bus up whenever the PHY owns dir.
//
// Ports
//   ulpi_clk     60 MHz ULPI clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   dir, nxt     PHY bus direction / throttle
//   data_out     byte driven onto the ULPI data bus while data_oe=1
//   data_oe      link drive enable
//   stp          end-of-packet strobe (data_out=00 normal end, FF abort)
//   tx_start     request, sampled only while idle; tx_pid/tx_pid_only latched with it
//   tx_data/tx_valid/tx_last/tx_ready  payload byte stream from the packet builder
//   busy         engine not idle
//   tx_done      one-cycle pulse, packet completed normally (with stp)
//   tx_err       one-cycle pulse, underrun / dir abort / retry exhaustion / nxt timeout
//   dbg_state    current FSM state encoding, for observation only
//
// Handshake: a payload byte moves on a cycle where tx_valid and tx_ready are
// both 1. tx_ready is only raised in DATA on a cycle with nxt=1 and dir=0,
// and the builder must keep tx_data stable while tx_valid=1 and no transfer
// has taken place.
`timescale 1ns/1ps
module ulpi_tx_engine #(
   parameter int MAX_RETRY   = 3,
   parameter int NXT_TIMEOUT = 64
) (
   input  logic       ulpi_clk,
   input  logic       rst,
   input  logic       dir,
   input  logic       nxt,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       stp,
   input  logic       tx_start,
   input  logic [3:0] tx_pid,
   input  logic       tx_pid_only,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic [2:0] dbg_state
);

   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam int TW = $clog2(NXT_TIMEOUT + 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TMO_LAST  = TW'(NXT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_DATA = 3'd2,
      S_STP  = 3'd3,
      S_ABRT = 3'd4,
      S_ERR  = 3'd5,
      S_WAIT = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic          dir_q;
   logic [3:0]    pid_q, pid_d;
   logic          pid_only_q, pid_only_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          turnaround;
   logic          drive;

   // A change of dir means one turnaround cycle on the bus: nobody drives.
   assign turnaround = (dir != dir_q);

   always_ff @(posedge ulpi_clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dir_q      <= 1'b0;
         pid_q      <= 4'h0;
         pid_only_q <= 1'b0;
         retry_q    <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir;
         pid_q      <= pid_d;
         pid_only_q <= pid_only_d;
         retry_q    <= retry_d;
         tmo_q      <= tmo_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pid_d      = pid_q;
      pid_only_d = pid_only_q;
      retry_d    = retry_q;
      tmo_d      = tmo_q;
      unique case (state_q)
         S_IDLE: begin
            // Start only with the bus settled on our side (no turnaround pending).
            if (tx_start && !dir && !dir_q) begin
               pid_d      = tx_pid;
               pid_only_d = tx_pid_only;
               retry_d    = '0;
               tmo_d      = '0;
               state_d    = S_CMD;
            end
         end
         S_CMD: begin
            if (dir) begin
               if (retry_q != '1) retry_d = retry_q + RW'(1);
               state_d = S_WAIT;
            end else if (nxt) begin
               state_d = pid_only_q ? S_STP : S_DATA;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DATA: begin
            // Once payload has started there is no clean way to resume.
            if (dir) begin
               state_d = S_ERR;
            end else if (nxt) begin
               if (!tx_valid)    state_d = S_ABRT;
               else if (tx_last) state_d = S_STP;
            end
         end
         S_STP, S_ABRT, S_ERR: state_d = S_IDLE;
         S_WAIT: begin
            // Hold through the PHY's ownership and the turnaround after it.
            if (!dir && !dir_q) begin
               if (retry_q > RETRY_LIM) begin
                  state_d = S_ERR;
               end else begin
                  tmo_d   = '0;
                  state_d = S_CMD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: Moore from state, except the DATA byte and tx_ready.
   always_comb begin
      data_out = 8'h00;
      stp      = 1'b0;
      tx_done  = 1'b0;
      tx_err   = 1'b0;
      tx_ready = 1'b0;
      drive    = 1'b0;
      case (state_q)
         S_CMD: begin
            data_out = {4'b0100, pid_q};
            drive    = 1'b1;
         end
         S_DATA: begin
            data_out = tx_data;
            drive    = 1'b1;
            tx_ready = nxt && !dir && tx_valid;
         end
         S_STP: begin
            stp     = 1'b1;
            tx_done = 1'b1;
            drive   = 1'b1;
         end
         S_ABRT: begin
            data_out = 8'hFF;
            stp      = 1'b1;
            tx_err   = 1'b1;
            drive    = 1'b1;
         end
         S_ERR: tx_err = 1'b1;
         default: ;
      endcase
   end

   assign data_oe   = drive && !dir && !turnaround;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ulpi_tx_engine.sv
`timescale 1ns/1ps
module tb_ulpi_tx_engine;

   localparam int MAX_RETRY   = 3;
   localparam int NXT_TIMEOUT = 64;
   localparam int BUDGET      = 400;

   logic       ulpi_clk = 1'b0;
   logic       rst, dir, nxt, tx_start, tx_pid_only, tx_valid, tx_last;
   logic [3:0] tx_pid;
   logic [7:0] tx_data, data_out;
   logic       data_oe, stp, tx_ready, busy, tx_done, tx_err;
   logic [2:0] dbg_state;

   always #5 ulpi_clk = ~ulpi_clk;

   ulpi_tx_engine #(.MAX_RETRY(MAX_RETRY), .NXT_TIMEOUT(NXT_TIMEOUT)) dut (
      .ulpi_clk(ulpi_clk), .rst(rst), .dir(dir), .nxt(nxt),
      .data_out(data_out), .data_oe(data_oe), .stp(stp),
      .tx_start(tx_start), .tx_pid(tx_pid), .tx_pid_only(tx_pid_only),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
      .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard: bytes the PHY should accept, in order.
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] pl[16];

   // Per-packet observations
   int         r_done, r_err, r_stp, r_ready, r_both, r_fwd_bad;
   logic       r_ended;
   logic [7:0] r_end;

   // Model outputs
   int         e_done, e_err, e_stp, e_ready;
   logic [7:0] e_end;

   typedef struct {
      logic [3:0] pid;
      logic       only;
      int         len;
      int         grabs;
      int         under;
      int         x_done;
      int         x_err;
      int         x_stp;
      int         x_ready;
      logic [7:0] x_end;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ulpi_clk);
      #1;
   endtask

   task automatic idle_inputs();
      dir = 1'b0; nxt = 1'b0; tx_start = 1'b0; tx_pid = 4'h0; tx_pid_only = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
   endtask

   task automatic settle();
      idle_inputs();
      repeat (2) tick();
   endtask

   // Leaves the bench at the first CMD cycle; pid inputs are scrambled afterwards
   // so the engine must be using its latched copy.
   task automatic start_pkt(input logic [3:0] pid, input logic only);
      tx_pid = pid; tx_pid_only = only; tx_start = 1'b1;
      tick();
      tx_start = 1'b0; tx_pid = ~pid; tx_pid_only = ~only;
   endtask

   // Behavioural reference: outcome of a packet from its scenario description.
   task automatic model_pkt(input logic [3:0] pid, input logic only, input int len,
                            input int grabs, input int under);
      exp_q.delete();
      e_ready = 0; e_end = 8'h00;
      if (grabs > MAX_RETRY) begin
         e_done = 0; e_err = 1; e_stp = 0;
      end else begin
         exp_q.push_back({4'b0100, pid});
         e_stp = 1;
         if (!only && under >= 0) begin
            for (int i = 0; i < under; i++) exp_q.push_back(pl[i]);
            exp_q.push_back(pl[under]);   // byte on the bus during the underrun cycle
            e_ready = under; e_done = 0; e_err = 1; e_end = 8'hFF;
         end else begin
            if (!only) for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
            e_ready = only ? 0 : len; e_done = 1; e_err = 0;
         end
      end
   endtask

   // Drives one packet scenario cycle by cycle and records what the PHY sees.
   task automatic run_pkt(input logic [3:0] pid, input logic only, input int len,
                          input int grabs, input int under, input int nxt_pct);
      int idx, grab_left, gphase;
      logic rdy;
      idx = 0; grab_left = grabs; gphase = 0;
      r_done = 0; r_err = 0; r_stp = 0; r_ready = 0; r_both = 0; r_fwd_bad = 0;
      r_ended = 1'b0; r_end = 8'h00;
      got_q.delete();
      start_pkt(pid, only);
      for (int c = 0; c < BUDGET; c++) begin
         if (grab_left > 0) begin
            nxt = 1'b0;
            dir = (gphase < 3);
            gphase++;
            if (gphase == 5) begin
               gphase = 0;
               grab_left--;
            end
         end else begin
            dir = 1'b0;
            nxt = ($urandom_range(0, 99) < nxt_pct);
         end
         tx_valid = (idx < len) && !(under >= 0 && idx == under);
         tx_data  = pl[idx < 16 ? idx : 15];
         tx_last  = (len > 0) && (idx == len - 1);
         @(negedge ulpi_clk);
         rdy = tx_ready;
         if (data_oe && nxt && !dir && !stp) got_q.push_back(data_out);
         if (tx_ready) r_ready++;
         if (tx_ready && data_out !== tx_data) r_fwd_bad++;
         if (stp) r_stp++;
         if (tx_done) r_done++;
         if (tx_err) r_err++;
         if (tx_done && tx_err) r_both++;
         if (tx_done || tx_err) begin
            r_end = data_out;
            r_ended = 1'b1;
         end
         tick();
         if (rdy) idx++;
         if (r_ended) break;
      end
      check("pkt_ended", r_ended, 1'b1);
      settle();
   endtask

   task automatic compare_pkt(input string tag, input int x_done, input int x_err,
                              input int x_stp, input int x_ready, input logic [7:0] x_end);
      check({tag, "_done"}, r_done, x_done);
      check({tag, "_err"}, r_err, x_err);
      check({tag, "_stp"}, r_stp, x_stp);
      check({tag, "_ready"}, r_ready, x_ready);
      check({tag, "_both"}, r_both, 0);
      check({tag, "_fwd"}, r_fwd_bad, 0);
      if (x_stp != 0) check({tag, "_end_byte"}, r_end, x_end);
      check({tag, "_bus_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_bus_byte"}, got_q[i], exp_q[i]);
   endtask

   // Payload stream of AA,55,01 with a per-DATA-cycle nxt pattern.
   task automatic stream_test(input string nm, input logic [15:0] pat, input int plen);
      logic [7:0] b[3];
      int idx, rc;
      b[0] = 8'hAA; b[1] = 8'h55; b[2] = 8'h01;
      idx = 0; rc = 0;
      start_pkt(4'h3, 1'b0);
      nxt = 1'b1; tx_valid = 1'b1; tx_data = b[0]; tx_last = 1'b0;
      @(negedge ulpi_clk);
      check({nm, "_cmd"}, data_out, 8'h43);
      check({nm, "_cmd_rdy"}, tx_ready, 1'b0);
      tick();
      for (int c = 0; c < plen; c++) begin
         nxt = pat[c]; tx_data = b[idx]; tx_last = (idx == 2);
         @(negedge ulpi_clk);
         check({nm, "_byte"}, data_out, b[idx]);
         check({nm, "_rdy"}, tx_ready, pat[c]);
         if (tx_ready) rc++;
         tick();
         if (pat[c]) idx++;
      end
      tx_valid = 1'b0; tx_last = 1'b0; nxt = 1'b0;
      @(negedge ulpi_clk);
      check({nm, "_stp"}, stp, 1'b1);
      check({nm, "_stp_data"}, data_out, 8'h00);
      check({nm, "_done"}, tx_done, 1'b1);
      check({nm, "_rdy_cnt"}, rc, 3);
      tick();
      @(negedge ulpi_clk);
      check({nm, "_idle"}, busy, 1'b0);
      settle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int cnt;
      logic seen, stp_seen;
      logic [3:0] pid;
      logic only;
      int len, grabs, under;

      vecs[0] = '{4'h2, 1'b1, 0, 0, -1, 1, 0, 1, 0, 8'h00};
      vecs[1] = '{4'h3, 1'b0, 3, 0, -1, 1, 0, 1, 3, 8'h00};
      vecs[2] = '{4'hB, 1'b0, 1, 2, -1, 1, 0, 1, 1, 8'h00};
      vecs[3] = '{4'h3, 1'b0, 4, 4, -1, 0, 1, 0, 0, 8'h00};
      vecs[4] = '{4'h1, 1'b0, 5, 0,  2, 0, 1, 1, 2, 8'hFF};
      vecs[5] = '{4'hA, 1'b1, 0, 3, -1, 1, 0, 1, 0, 8'h00};
      vecs[6] = '{4'h9, 1'b0, 2, 0,  0, 0, 1, 1, 0, 8'hFF};
      vecs[7] = '{4'h5, 1'b0, 8, 3, -1, 1, 0, 1, 8, 8'h00};

      // Reset
      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      @(negedge ulpi_clk);
      check("rst_data_out", data_out, 8'h00);
      check("rst_data_oe", data_oe, 1'b0);
      check("rst_stp", stp, 1'b0);
      check("rst_ready", tx_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_err", tx_err, 1'b0);
      tick();
      rst = 1'b0;
      settle();

      // T1: handshake packet, nxt on second CMD cycle
      start_pkt(4'h2, 1'b1);
      @(negedge ulpi_clk);
      check("t1_cmd1", data_out, 8'h42);
      check("t1_oe", data_oe, 1'b1);
      check("t1_busy", busy, 1'b1);
      tick(); nxt = 1'b1;
      @(negedge ulpi_clk);
      check("t1_cmd2", data_out, 8'h42);
      tick(); nxt = 1'b0;
      @(negedge ulpi_clk);
      check("t1_stp", stp, 1'b1);
      check("t1_stp_data", data_out, 8'h00);
      check("t1_done", tx_done, 1'b1);
      check("t1_err", tx_err, 1'b0);
      tick();
      @(negedge ulpi_clk);
      check("t1_done_pulse", tx_done, 1'b0);
      check("t1_idle", busy, 1'b0);
      settle();

      // T2 / T3: streaming, then with nxt stalled on 0x55 for two cycles
      stream_test("t2", 16'h0007, 3);
      stream_test("t3", 16'h0019, 5);

      // T4: four PHY grabs during CMD exhaust the retries
      start_pkt(4'h3, 1'b0);
      @(negedge ulpi_clk);
      check("t4_cmd", data_out, 8'h43);
      for (int g = 1; g <= 4; g++) begin
         tick(); dir = 1'b1;
         @(negedge ulpi_clk);
         check("t4_oe_grab", data_oe, 1'b0);
         tick(); tick(); tick(); dir = 1'b0;
         @(negedge ulpi_clk);
         check("t4_oe_turn", data_oe, 1'b0);
         check("t4_busy", busy, 1'b1);
         tick(); tick();
         @(negedge ulpi_clk);
         if (g < 4) begin
            check("t4_reissue", data_out, 8'h43);
            check("t4_reissue_oe", data_oe, 1'b1);
            check("t4_no_err", tx_err, 1'b0);
         end else begin
            check("t4_err", tx_err, 1'b1);
            check("t4_err_stp", stp, 1'b0);
            check("t4_err_oe", data_oe, 1'b0);
         end
      end
      tick();
      @(negedge ulpi_clk);
      check("t4_err_pulse", tx_err, 1'b0);
      check("t4_idle", busy, 1'b0);
      settle();

      // T5a: underrun in DATA gives an FF abort
      start_pkt(4'h3, 1'b0);
      nxt = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
      tick();
      @(negedge ulpi_clk);
      check("t5_first_rdy", tx_ready, 1'b1);
      tick(); tx_valid = 1'b0;
      @(negedge ulpi_clk);
      check("t5_under_rdy", tx_ready, 1'b0);
      tick(); nxt = 1'b0;
      @(negedge ulpi_clk);
      check("t5_abrt_stp", stp, 1'b1);
      check("t5_abrt_data", data_out, 8'hFF);
      check("t5_abrt_err", tx_err, 1'b1);
      check("t5_abrt_done", tx_done, 1'b0);
      check("t5_abrt_oe", data_oe, 1'b1);
      settle();

      // T5b: dir in DATA aborts without stp
      start_pkt(4'h3, 1'b0);
      nxt = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
      tick(); nxt = 1'b0;
      tick(); dir = 1'b1;
      @(negedge ulpi_clk);
      check("t5_dir_oe", data_oe, 1'b0);
      check("t5_dir_rdy", tx_ready, 1'b0);
      tick(); dir = 1'b0; tx_valid = 1'b0;
      @(negedge ulpi_clk);
      check("t5_dir_err", tx_err, 1'b1);
      check("t5_dir_stp", stp, 1'b0);
      check("t5_dir_err_oe", data_oe, 1'b0);
      settle();

      // T6: nxt never comes
      start_pkt(4'h3, 1'b0);
      cnt = 0; seen = 1'b0; stp_seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge ulpi_clk);
         if (stp) stp_seen = 1'b1;
         if (tx_err) begin
            seen = 1'b1;
            break;
         end
         tick();
         cnt++;
      end
      check("t6_err_seen", seen, 1'b1);
      check("t6_err_cycle", cnt, NXT_TIMEOUT);
      check("t6_no_stp", stp_seen, 1'b0);
      tick();
      settle();

      // Reset in the middle of DATA
      start_pkt(4'h3, 1'b0);
      nxt = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
      tick(); nxt = 1'b0;
      tick(); rst = 1'b1; nxt = 1'b1;
      tick();
      @(negedge ulpi_clk);
      check("rstd_busy", busy, 1'b0);
      check("rstd_oe", data_oe, 1'b0);
      check("rstd_data", data_out, 8'h00);
      check("rstd_stp", stp, 1'b0);
      check("rstd_ready", tx_ready, 1'b0);
      check("rstd_done", tx_done, 1'b0);
      check("rstd_err", tx_err, 1'b0);
      tick(); rst = 1'b0;
      settle();

      // Table-driven packet scenarios
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
         model_pkt(vecs[v].pid, vecs[v].only, vecs[v].len, vecs[v].grabs, vecs[v].under);
         run_pkt(vecs[v].pid, vecs[v].only, vecs[v].len, vecs[v].grabs, vecs[v].under, 60);
         compare_pkt("vec", vecs[v].x_done, vecs[v].x_err, vecs[v].x_stp,
                     vecs[v].x_ready, vecs[v].x_end);
      end

      // Randomized packets against the reference model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
         pid   = 4'($urandom_range(0, 15));
         only  = ($urandom_range(0, 3) == 0);
         len   = only ? 0 : $urandom_range(1, 12);
         grabs = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
         under = (!only && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
         model_pkt(pid, only, len, grabs, under);
         run_pkt(pid, only, len, grabs, under, $urandom_range(30, 100));
         compare_pkt("rnd", e_done, e_err, e_stp, e_ready, e_end);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
